// File: rtl/y_multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM state encoding,
// supported opcodes, ALU operation codes and small opcode helpers.
package y_multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_IALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_BEQ   = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == OPC_R) || (opc == OPC_IALU) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BEQ) || (opc == OPC_JAL);
    endfunction

    // Successor of EXEC when EXEC is not the last state of the instruction.
    function automatic state_t exec_next(input logic [6:0] opc);
        if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
            return S_MEM;
        end
        return S_WB;
    endfunction

endpackage

// File: rtl/y_multicycle_ctrl_if.sv
// Bundle between the multicycle controller and its datapath: fetch/decode/execute
// inputs plus the controller's PC, IR, strobes, controls and status.
interface y_multicycle_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      ins;
    logic             zero;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  j_target;
    logic [XLEN-1:0]  pc;
    logic [31:0]      ir;
    logic             ir_write;
    logic             pc_write;
    logic             RegWrite;
    logic             ALUSrc;
    logic             Mem2Reg;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       op;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             done;
    logic             illegal;

    // Datapath / environment side.
    modport master (
        output start, ins, zero, br_target, j_target,
        input  pc, ir, ir_write, pc_write, RegWrite, ALUSrc, Mem2Reg,
               MemRead, MemWrite, op, state, retired, done, illegal
    );

    // Controller side.
    modport slave (
        input  start, ins, zero, br_target, j_target,
        output pc, ir, ir_write, pc_write, RegWrite, ALUSrc, Mem2Reg,
               MemRead, MemWrite, op, state, retired, done, illegal
    );
endinterface

// File: rtl/y_ctrl_decode.sv
// Moore control decode: maps the current state and latched opcode to the
// datapath controls and the IR/PC write strobes.
module y_ctrl_decode
    import y_multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] opcode,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic       mem2reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] op
);

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        mem2reg   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        op        = 3'b000;
        case (state)
            S_FETCH: ir_write = 1'b1;
            // beq retires straight out of EXEC; everything else continues.
            S_EXEC: begin
                alu_src  = !((opcode == OPC_R) || (opcode == OPC_BEQ));
                op       = (opcode == OPC_BEQ) ? ALU_SUB : ALU_ADD;
                pc_write = (opcode == OPC_BEQ);
            end
            S_MEM: begin
                mem_read  = (opcode == OPC_LOAD);
                mem_write = (opcode == OPC_STORE);
                pc_write  = (opcode == OPC_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = (opcode == OPC_LOAD);
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/y_multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: owns the FSM, PC, IR and retire
// counter; control decode is delegated to y_ctrl_decode.
module y_multicycle_ctrl
    import y_multicycle_ctrl_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] PC_RESET  = 'h28,
    parameter int              MAX_INSNS = 11,
    parameter int              CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    y_multicycle_ctrl_if.slave bus
);

    state_t           state_reg;
    logic [XLEN-1:0]  pc_reg;
    logic [31:0]      ir_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             done_reg;
    logic             illegal_reg;

    logic [6:0]       opcode;
    logic             ir_write, pc_write, reg_write, alu_src, mem2reg, mem_read, mem_write;
    logic [2:0]       op;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] retired_next;
    logic             limit_hit;

    assign opcode       = ir_reg[6:0];
    assign retired_next = retired_reg + CNT_W'(1);
    assign limit_hit    = (MAX_INSNS != 0) && (retired_next == CNT_W'(MAX_INSNS));

    always_comb begin
        pc_next = pc_reg + XLEN'(4);
        if (opcode == OPC_JAL) begin
            pc_next = bus.j_target;
        end else if ((opcode == OPC_BEQ) && bus.zero) begin
            pc_next = bus.br_target;
        end
    end

    y_ctrl_decode u_decode (
        .state     (state_reg),
        .opcode    (opcode),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .mem2reg   (mem2reg),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .op        (op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pc_reg      <= PC_RESET;
            ir_reg      <= '0;
            retired_reg <= '0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: if (bus.start) state_reg <= S_FETCH;
                S_FETCH: begin
                    ir_reg    <= bus.ins;
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_reg <= S_EXEC;
                    end else begin
                        state_reg   <= S_HALT;
                        illegal_reg <= 1'b1;
                    end
                end
                // pc_write marks the final state of the current instruction.
                S_EXEC, S_MEM, S_WB: begin
                    if (pc_write) begin
                        pc_reg      <= pc_next;
                        retired_reg <= retired_next;
                        if (limit_hit) begin
                            state_reg <= S_HALT;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end else if (state_reg == S_EXEC) begin
                        state_reg <= exec_next(opcode);
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_HALT: begin
                    if (bus.start) begin
                        state_reg   <= S_FETCH;
                        pc_reg      <= PC_RESET;
                        retired_reg <= '0;
                        done_reg    <= 1'b0;
                        illegal_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.pc       = pc_reg;
    assign bus.ir       = ir_reg;
    assign bus.ir_write = ir_write;
    assign bus.pc_write = pc_write;
    assign bus.RegWrite = reg_write;
    assign bus.ALUSrc   = alu_src;
    assign bus.Mem2Reg  = mem2reg;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.op       = op;
    assign bus.state    = state_reg;
    assign bus.retired  = retired_reg;
    assign bus.done     = done_reg;
    assign bus.illegal  = illegal_reg;

endmodule

// File: doc/y_multicycle_ctrl.md
Y_MULTICYCLE_CTRL -- requirements
Module: y_multicycle_ctrl

Interface
REQ-001 Parameter XLEN, default 32: PC and target width.
REQ-002 Parameter PC_RESET, default 32'h28: PC value after reset and on restart.
REQ-003 Parameter MAX_INSNS, default 11: instructions retired before halting; 0 means unlimited.
REQ-004 Parameter CNT_W, default 16: retire-counter width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 start  in  1  begin execution from IDLE or HALT.
REQ-008 ins  in  32  instruction word from the fetch stage at current pc.
REQ-009 zero  in  1  ALU zero flag from the execute stage.
REQ-010 br_target, j_target  in  XLEN  branch and jal targets from the decode stage.
REQ-011 pc  out  XLEN  current program counter.
REQ-012 ir  out  32  latched instruction register.
REQ-013 ir_write, pc_write  out  1  one-cycle strobes for IR load and PC update.
REQ-014 RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  out  1  datapath controls.
REQ-015 op  out  3  ALU op; 3'b010 add, 3'b110 subtract.
REQ-016 state  out  3  current FSM state encoding.
REQ-017 retired  out  CNT_W  instructions completed since start.
REQ-018 done, illegal  out  1  halted on count limit or on an unsupported opcode.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-020 IDLE->FETCH on start=1; otherwise remain in IDLE.
REQ-021 FETCH SHALL assert ir_write and load ir<=ins, then go to DECODE.
REQ-022 DECODE SHALL classify ir[6:0] and go to EXEC; unsupported opcodes go to HALT with illegal=1 and no retire.
REQ-023 Supported opcodes and their state sequences:
- 0x33 R-type and 0x13 I-ALU: EXEC->WB.
- 0x03 load: EXEC->MEM->WB.
- 0x23 store: EXEC->MEM.
- 0x63 beq: EXEC.
- 0x6F jal: EXEC->WB.
REQ-024 Control outputs SHALL be Moore per state and opcode; every control output is 0 outside the states listed below.
REQ-025 EXEC: ALUSrc=0 for 0x33/0x63, else 1; op=3'b110 for 0x63, else 3'b010.
REQ-026 MEM: MemRead=1 for load; MemWrite=1 for store.
REQ-027 WB: RegWrite=1; Mem2Reg=1 only for load.
REQ-028 The last state of each instruction SHALL assert pc_write, increment retired, and go to FETCH, or to HALT with done=1 when retired+1==MAX_INSNS (MAX_INSNS!=0).
REQ-029 PC update on pc_write:
- beq: pc<=br_target if zero=1, else pc+4.
- jal: pc<=j_target.
- all others: pc<=pc+4.
- Arithmetic is modulo 2^XLEN.
REQ-030 beq SHALL take 3 cycles, store/R/I/jal 4 cycles, and load 5 cycles per instruction.
REQ-031 start SHALL be ignored outside IDLE and HALT.
REQ-032 start in HALT SHALL clear retired, done and illegal, set pc<=PC_RESET, and go to FETCH.
REQ-033 retired SHALL wrap at 2^CNT_W when MAX_INSNS=0.

Reset
REQ-034 On rising clk with rst_n=0:
- state<=IDLE, pc<=PC_RESET, ir<=0, retired<=0.
- done, illegal and all controls <=0.
- This applies mid-instruction, overriding start and any pending pc_write.

Structure
REQ-035 A shared package SHALL hold the state enum, opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F) and ALU op constants (ADD=3'b010, SUB=3'b110).
REQ-036 One sub-module, y_ctrl_decode, SHALL map (state, ir[6:0]) to the control outputs combinationally; the FSM, PC, IR and counter stay in the top module.

Verification
REQ-037 Reset, then start with ins=32'h00208033 (add) held → ir_write in cycle 1, EXEC ALUSrc=0 op=010, WB RegWrite=1, pc 0x28→0x2C after 4 cycles, retired=1.
REQ-038 Load (opcode 0x03) → MemRead=1 only in MEM, Mem2Reg=1 and RegWrite=1 only in WB, 5 cycles total.
REQ-039 beq with zero=1 and br_target=0x40 → pc=0x40 after 3 cycles; repeated with zero=0 → pc=0x2C.
REQ-040 Eleven add instructions with MAX_INSNS=11 → done=1, state=HALT, retired=11, pc=0x54; start then → pc=0x28, retired=0.
REQ-041 ins opcode 0x7F → HALT after DECODE, illegal=1, retired unchanged; rst_n=0 asserted in MEM of a load → IDLE, pc=0x28, MemRead=0 the next cycle.
